// File: rtl/pwm_settle_gate.sv
// pwm_settle_gate
//   Multi-channel settle detector placed between the duty-cycle registers and the
//   PWM generators. Each channel raises en while its duty word is changing. Once
//   the word has held for S cycles, the channel latches the word to data_out,
//   pulses upd for one cycle and drops en. S is one settle-time register shared
//   by all channels and can be reprogrammed at run time. Any channel can be
//   masked so that it stays idle.
//
// Ports
//   clk           in   1        clock
//   reset         in   1        synchronous, active-high reset
//   data_in       in   NCH*N    packed duty words; channel k = data_in[k*N +: N]
//   settle_cycles in   CW       new settle time, taken when settle_load=1 (0 means 1)
//   settle_load   in   1        load settle_cycles into the settle register
//   ch_mask       in   NCH      1 = channel held idle
//   en            out  NCH      registered; 1 while channel k is settling
//   data_out      out  NCH*N    registered last-settled word per channel
//   upd           out  NCH      registered one-cycle pulse when data_out[k] updates
//   any_busy      out  1        OR of en
module pwm_settle_gate #(
  parameter int N              = 8,
  parameter int NCH            = 4,
  parameter int CW             = 16,
  parameter int DEFAULT_SETTLE = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH*N-1:0] data_in,
  input  logic [CW-1:0]    settle_cycles,
  input  logic             settle_load,
  input  logic [NCH-1:0]   ch_mask,
  output logic [NCH-1:0]   en,
  output logic [NCH*N-1:0] data_out,
  output logic [NCH-1:0]   upd,
  output logic             any_busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETTLING = 2'd1;
  localparam logic [1:0] STABLE   = 2'd2;

  // A settle time of zero cannot be met, so it is treated as one cycle.
  function automatic logic [CW-1:0] clamp_settle(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  // The counter holds at its maximum instead of wrapping back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  logic [CW-1:0] s_reg;

  always_ff @(posedge clk) begin
    if (reset)
      s_reg <= CW'(DEFAULT_SETTLE);
    else if (settle_load)
      s_reg <= clamp_settle(settle_cycles);
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [N-1:0]  prev;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic          en_r;
    logic          upd_r;
    logic [N-1:0]  dout_r;
    logic [N-1:0]  din;
    logic          change;
    logic [CW:0]   cnt_next;

    assign din      = data_in[k*N +: N];
    assign change   = (din != prev);
    // Compare one bit wider than the counter so cnt+1 cannot overflow the check.
    assign cnt_next = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
      if (reset) begin
        prev   <= '0;
        cnt    <= '0;
        state  <= IDLE;
        en_r   <= 1'b0;
        upd_r  <= 1'b0;
        dout_r <= '0;
      end else begin
        // prev follows the input even while the channel is masked, so an unmask
        // does not see a stale difference as a change.
        prev  <= din;
        upd_r <= 1'b0;
        if (ch_mask[k]) begin
          state <= IDLE;
          cnt   <= '0;
          en_r  <= 1'b0;
        end else begin
          case (state)
            SETTLING: begin
              if (change) begin
                cnt <= '0;
              end else if (cnt_next >= {1'b0, s_reg}) begin
                state  <= STABLE;
                dout_r <= din;
                upd_r  <= 1'b1;
                en_r   <= 1'b0;
                cnt    <= '0;
              end else begin
                cnt <= sat_inc(cnt);
              end
            end
            IDLE, STABLE: begin
              if (change) begin
                state <= SETTLING;
                cnt   <= '0;
                en_r  <= 1'b1;
              end else begin
                en_r <= 1'b0;
              end
            end
            default: begin
              state <= IDLE;
              cnt   <= '0;
              en_r  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign en[k]             = en_r;
    assign upd[k]            = upd_r;
    assign data_out[k*N +: N] = dout_r;
  end

  assign any_busy = |en;

endmodule

// File: tb/tb_pwm_settle_gate.sv
// tb_pwm_settle_gate
//   Drives directed scenarios followed by a randomized phase. After every clock
//   edge the reference model pushes the expected outputs into a queue, and a
//   separate monitor pops each entry on the falling edge and compares it with the
//   DUT. The model describes each channel by the number of edges since its word
//   last changed. A channel is settling until that age reaches S, and on that edge
//   it publishes the word.
module tb_pwm_settle_gate;
  localparam int N   = 8;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int DEF = 10;

  logic             clk;
  logic             reset;
  logic [NCH*N-1:0] data_in;
  logic [CW-1:0]    settle_cycles;
  logic             settle_load;
  logic [NCH-1:0]   ch_mask;
  logic [NCH-1:0]   en;
  logic [NCH*N-1:0] data_out;
  logic [NCH-1:0]   upd;
  logic             any_busy;

  pwm_settle_gate #(.N(N), .NCH(NCH), .CW(CW), .DEFAULT_SETTLE(DEF)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .settle_cycles(settle_cycles),
    .settle_load(settle_load), .ch_mask(ch_mask), .en(en), .data_out(data_out),
    .upd(upd), .any_busy(any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   upd;
    logic [NCH*N-1:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state.
  int           m_s;
  logic [N-1:0] m_prev [NCH];
  logic [N-1:0] m_dout [NCH];
  bit           m_busy [NCH];
  int           m_age  [NCH];

  task automatic model_edge(input logic r, input logic [NCH*N-1:0] d,
                            input logic [CW-1:0] sc, input logic sl,
                            input logic [NCH-1:0] mk);
    exp_t e;
    e = '0;
    if (r) begin
      m_s = DEF;
      for (int k = 0; k < NCH; k++) begin
        m_prev[k] = '0; m_dout[k] = '0; m_busy[k] = 0; m_age[k] = 0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        logic [N-1:0] w;
        w = d[k*N +: N];
        if (mk[k]) begin
          m_busy[k] = 0;
          m_age[k]  = 0;
        end else if (w != m_prev[k]) begin
          m_busy[k] = 1;
          m_age[k]  = 0;
        end else if (m_busy[k]) begin
          m_age[k]++;
          if (m_age[k] >= m_s) begin
            m_busy[k] = 0;
            m_dout[k] = w;
            e.upd[k]  = 1'b1;
          end
        end
        m_prev[k] = w;
      end
      if (sl) m_s = (sc == 0) ? 1 : int'(sc);
    end
    for (int k = 0; k < NCH; k++) begin
      e.en[k]          = m_busy[k];
      e.dout[k*N +: N] = m_dout[k];
    end
    exp_q.push_back(e);
  endtask

  // Applies the current inputs across one rising edge and records the expectation.
  task automatic step();
    logic             r, sl;
    logic [NCH*N-1:0] d;
    logic [CW-1:0]    sc;
    logic [NCH-1:0]   mk;
    r = reset; d = data_in; sc = settle_cycles; sl = settle_load; mk = ch_mask;
    @(posedge clk);
    model_edge(r, d, sc, sl, mk);
    cyc++;
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ch(input int k, input logic [N-1:0] v);
    data_in[k*N +: N] = v;
  endtask

  task automatic load_s(input logic [CW-1:0] v);
    settle_cycles = v;
    settle_load   = 1'b1;
    step();
    settle_load   = 1'b0;
  endtask

  // Monitor: compares whatever the model has queued for the edge just taken.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (en !== e.en) begin
        bad++;
        $display("FAIL en cyc=%0d got=%b want=%b", cyc, en, e.en);
      end
      total++;
      if (upd !== e.upd) begin
        bad++;
        $display("FAIL upd cyc=%0d got=%b want=%b", cyc, upd, e.upd);
      end
      total++;
      if (data_out !== e.dout) begin
        bad++;
        $display("FAIL data_out cyc=%0d got=%h want=%h", cyc, data_out, e.dout);
      end
      total++;
      if (any_busy !== (|e.en)) begin
        bad++;
        $display("FAIL any_busy cyc=%0d got=%b want=%b", cyc, any_busy, |e.en);
      end
    end
  end

  initial begin
    reset = 1'b1; data_in = '0; settle_cycles = '0; settle_load = 1'b0; ch_mask = '0;
    #1;
    hold(3);
    reset = 1'b0;
    hold(2);

    // Single channel with the default settle time.
    set_ch(0, 8'h40); hold(15);

    // A glitch mid-settle restarts the window.
    set_ch(1, 8'h10); hold(6);
    set_ch(1, 8'h11); hold(14);

    // Zero settle time behaves as one cycle; then a 3-cycle window.
    load_s(16'd0);
    set_ch(0, 8'h41); hold(4);
    load_s(16'd3);
    set_ch(0, 8'h42); hold(6);

    // Shrinking S while a channel is deep into its window.
    load_s(16'd10);
    set_ch(2, 8'h77); hold(8);
    load_s(16'd4);
    hold(4);

    // Masked channel ignores changes, then settles only on a later change.
    ch_mask = 4'b1000;
    set_ch(3, 8'h05); hold(3);
    set_ch(3, 8'h06); hold(3);
    ch_mask = 4'b0000; hold(5);
    set_ch(3, 8'h07); hold(13);

    // All channels change together; reset lands mid-settle.
    data_in = 32'hA1B2C3D4; hold(4);
    reset = 1'b1; hold(1);
    reset = 1'b0; hold(2);
    data_in = 32'h01020304; hold(13);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)
        set_ch(int'($urandom_range(0, NCH-1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 39) == 0) begin
        settle_cycles = 16'($urandom_range(0, 7));
        settle_load   = 1'b1;
      end else begin
        settle_load = 1'b0;
      end
      if ($urandom_range(0, 29) == 0)
        ch_mask[$urandom_range(0, NCH-1)] ^= 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; settle_load = 1'b0;
    hold(2);

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
